// File: rtl/fir_out_collector.sv
// Output-side collector for the 16-tap FIR: drops pipeline-fill samples, buffers results in a FIFO,
// and streams them out over valid/ready. Define FIR_COLLECT_SAT_DETECT_EN to count full-scale samples.
module fir_out_collector #(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 16,
    parameter int FILL_SAMPLES = 24,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [DATA_WIDTH-1:0]      y_in,
    input  logic                       flush,
    input  logic                       clr_status,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       fill_done,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       drop_count,
    output logic [CNT_WIDTH-1:0]       sat_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int DISC_W = $clog2(FILL_SAMPLES + 1);

    typedef enum logic {DISCARD, COLLECT} state_t;

    state_t                  state_q, state_d;
    logic [DISC_W-1:0]       disc_cnt_q, disc_cnt_d;
    logic                    fill_done_q, fill_done_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]    drop_count_q, drop_count_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    capture;
    logic                    pop;
    logic                    full;
    logic                    push_req;
    logic                    push;
    logic                    drop;
    logic [DATA_WIDTH-1:0]   head;

    // Flush masks both capture and pop so the same-cycle events are ignored.
    always_comb begin
        capture  = enable & ~flush;
        pop      = m_valid_q & m_ready & ~flush;
        full     = (level_q == LVL_W'(DEPTH));
        push_req = capture & (state_q == COLLECT);
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    always_comb begin
        state_d     = state_q;
        disc_cnt_d  = disc_cnt_q;
        fill_done_d = fill_done_q;
        if (flush) begin
            state_d     = DISCARD;
            disc_cnt_d  = '0;
            fill_done_d = 1'b0;
        end else if (capture && state_q == DISCARD) begin
            if (disc_cnt_q == DISC_W'(FILL_SAMPLES - 1)) begin
                state_d     = COLLECT;
                disc_cnt_d  = '0;
                fill_done_d = 1'b1;
            end else begin
                disc_cnt_d = disc_cnt_q + DISC_W'(1);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // The output register loads the new head; a push landing on the head slot is forwarded
    // because the memory write has not happened yet on this edge.
    always_comb begin
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            head = y_in;
        end else begin
            head = mem_q[rd_ptr_d];
        end
        m_valid_d = (level_d != '0);
        m_data_d  = m_valid_d ? head : m_data_q;
    end

    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clr_status) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DISCARD;
            disc_cnt_q   <= '0;
            fill_done_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            disc_cnt_q   <= disc_cnt_d;
            fill_done_q  <= fill_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= y_in;
    end

`ifdef FIR_COLLECT_SAT_DETECT_EN
    localparam logic [DATA_WIDTH-1:0] POS_FS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_FS = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;
    logic                 sat_hit;

    // Counted on every collect-phase capture, including samples that end up dropped.
    always_comb begin
        sat_hit     = push_req & ((y_in == POS_FS) | (y_in == NEG_FS));
        sat_count_d = sat_count_q;
        if (clr_status) begin
            sat_count_d = '0;
        end else if (sat_hit && sat_count_q != '1) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_count_q <= '0;
        else        sat_count_q <= sat_count_d;
    end

    assign sat_count = sat_count_q;
`else
    assign sat_count = '0;
`endif

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign level      = level_q;
    assign fill_done  = fill_done_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fir_out_collector.sv
// Directed self-checking bench for fir_out_collector (default parameters; sat checks follow
// whether FIR_COLLECT_SAT_DETECT_EN is defined).
module tb_fir_out_collector;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] y_in;
    logic        flush;
    logic        clr_status;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [4:0]  level;
    logic        fill_done;
    logic        overflow;
    logic [15:0] drop_count;
    logic [15:0] sat_count;

    int total;
    int bad;

    fir_out_collector #(
        .DATA_WIDTH(16), .DEPTH(16), .FILL_SAMPLES(24), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .y_in(y_in), .flush(flush),
        .clr_status(clr_status), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level), .fill_done(fill_done), .overflow(overflow),
        .drop_count(drop_count), .sat_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge: one capture on the next rising edge, returns at the following falling edge.
    task automatic strobe(input logic [15:0] v);
        enable = 1'b1;
        y_in   = v;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; y_in = '0; flush = 1'b0; clr_status = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid got=%0b want=0", m_valid); end
        total++; if (m_data !== 16'h0) begin bad++; $display("[TB] FAIL reset_m_data got=%h want=0000", m_data); end
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", level); end
        total++; if (fill_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_fill_done got=%0b want=0", fill_done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%0b want=0", overflow); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_drop_count got=%0d want=0", drop_count); end
        total++; if (sat_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_sat_count got=%0d want=0", sat_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        m_ready = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            strobe(16'(i));
            total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL fill_no_valid strobe=%0d got=%0b want=0", i, m_valid); end
            total++; if (fill_done !== (i == 24)) begin bad++; $display("[TB] FAIL fill_done strobe=%0d got=%0b want=%0b", i, fill_done, (i == 24)); end
        end
        for (int i = 25; i <= 27; i++) begin
            strobe(16'(i));
            total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL fill_valid strobe=%0d got=%0b want=1", i, m_valid); end
            total++; if (m_data !== 16'(i)) begin bad++; $display("[TB] FAIL fill_data got=%0d want=%0d", m_data, i); end
            total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL fill_level got=%0d want=1", level); end
        end
        @(negedge clk);
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL fill_drained_valid got=%0b want=0", m_valid); end
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL fill_drained_level got=%0d want=0", level); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        strobe(16'h1234);
        strobe(16'h5678);
        @(negedge clk);
        total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid got=%0b want=1", m_valid); end
        total++; if (m_data !== 16'h1234) begin bad++; $display("[TB] FAIL bp_hold got=%h want=1234", m_data); end
        total++; if (level !== 5'd2) begin bad++; $display("[TB] FAIL bp_level got=%0d want=2", level); end
        m_ready = 1'b1;
        @(negedge clk);
        total++; if (m_data !== 16'h5678) begin bad++; $display("[TB] FAIL bp_second got=%h want=5678", m_data); end
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL bp_level1 got=%0d want=1", level); end
        @(negedge clk);
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty_valid got=%0b want=0", m_valid); end
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL bp_empty_level got=%0d want=0", level); end
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        for (int i = 0; i < 18; i++) strobe(16'h0100 + 16'(i));
        total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL ovf_level got=%0d want=16", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%0b want=1", overflow); end
        total++; if (drop_count !== 16'd2) begin bad++; $display("[TB] FAIL ovf_drop_count got=%0d want=2", drop_count); end
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++; if (m_data !== 16'h0100 + 16'(i)) begin bad++; $display("[TB] FAIL ovf_drain idx=%0d got=%h want=%h", i, m_data, 16'h0100 + 16'(i)); end
            @(negedge clk);
        end
        total++; if (level !== 5'd0 || m_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_empty level=%0d valid=%0b want 0/0", level, m_valid); end
    endtask

    task automatic test_full_push_pop();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) strobe(16'h0200 + 16'(i));
        total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL fpp_full got=%0d want=16", level); end
        m_ready = 1'b1;
        strobe(16'h02FF);
        total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL fpp_level got=%0d want=16", level); end
        total++; if (drop_count !== 16'd2) begin bad++; $display("[TB] FAIL fpp_no_drop got=%0d want=2", drop_count); end
        for (int i = 1; i < 16; i++) begin
            total++; if (m_data !== 16'h0200 + 16'(i)) begin bad++; $display("[TB] FAIL fpp_drain idx=%0d got=%h want=%h", i, m_data, 16'h0200 + 16'(i)); end
            @(negedge clk);
        end
        total++; if (m_data !== 16'h02FF || m_valid !== 1'b1) begin bad++; $display("[TB] FAIL fpp_last got=%h/%0b want=02ff/1", m_data, m_valid); end
        @(negedge clk);
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL fpp_empty got=%0d want=0", level); end
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) strobe(16'h0300 + 16'(i));
        total++; if (level !== 5'd5) begin bad++; $display("[TB] FAIL flush_pre_level got=%0d want=5", level); end
        flush = 1'b1; enable = 1'b1; m_ready = 1'b1; y_in = 16'h0999;
        @(negedge clk);
        flush = 1'b0; enable = 1'b0;
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL flush_level got=%0d want=0", level); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid got=%0b want=0", m_valid); end
        total++; if (fill_done !== 1'b0) begin bad++; $display("[TB] FAIL flush_fill_done got=%0b want=0", fill_done); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL flush_overflow got=%0b want=1", overflow); end
        total++; if (drop_count !== 16'd2) begin bad++; $display("[TB] FAIL flush_drop_count got=%0d want=2", drop_count); end
        for (int i = 1; i <= 24; i++) begin
            strobe(16'h0400 + 16'(i));
            total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL refill_no_valid strobe=%0d got=%0b want=0", i, m_valid); end
            total++; if (fill_done !== (i == 24)) begin bad++; $display("[TB] FAIL refill_done strobe=%0d got=%0b want=%0b", i, fill_done, (i == 24)); end
        end
        strobe(16'h0ABC);
        total++; if (m_valid !== 1'b1 || m_data !== 16'h0ABC) begin bad++; $display("[TB] FAIL refill_first got=%h/%0b want=0abc/1", m_data, m_valid); end
        @(negedge clk);
    endtask

    task automatic test_sat_count();
        logic [15:0] exp_sat;
`ifdef FIR_COLLECT_SAT_DETECT_EN
        exp_sat = 16'd2;
`else
        exp_sat = 16'd0;
`endif
        m_ready = 1'b1;
        strobe(16'h7FFF);
        total++; if (m_data !== 16'h7FFF) begin bad++; $display("[TB] FAIL sat_passthru_pos got=%h want=7fff", m_data); end
        strobe(16'h8000);
        total++; if (m_data !== 16'h8000) begin bad++; $display("[TB] FAIL sat_passthru_neg got=%h want=8000", m_data); end
        strobe(16'h7FFE);
        @(negedge clk);
        total++; if (sat_count !== exp_sat) begin bad++; $display("[TB] FAIL sat_count got=%0d want=%0d", sat_count, exp_sat); end
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        total++; if (sat_count !== 16'd0) begin bad++; $display("[TB] FAIL sat_clr got=%0d want=0", sat_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL clr_overflow got=%0b want=0", overflow); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL clr_drop_count got=%0d want=0", drop_count); end
        clr_status = 1'b1;
        strobe(16'h8000);
        clr_status = 1'b0;
        total++; if (sat_count !== 16'd0) begin bad++; $display("[TB] FAIL sat_clr_wins got=%0d want=0", sat_count); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        strobe(16'h0055);
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL areset_pre_level got=%0d want=1", level); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (level !== 5'd0 || m_valid !== 1'b0 || fill_done !== 1'b0) begin
            bad++; $display("[TB] FAIL areset_async level=%0d valid=%0b fill=%0b want 0/0/0", level, m_valid, fill_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_sat_count();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
